ups_rst_seq: RTL and testbench

Reset sequencer that sits directly downstream of the power-on-reset generator. It takes the POR-derived synchronous reset, a debounced front-panel reset button and a software reset request. From these it produces per-subsystem active-high resets, released one stage at a time in index order. Each stage must acknowledge readiness before the next stage is released. Sequence completion, sequence fault and the cause of the last reset are reported to the supervisor logic.

---
 rtl/ups_rst_seq.sv | 145 ++++++++++++++
 tb/tb_ups_rst_seq.sv | 425 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ups_rst_seq.sv
// ups_rst_seq: releases per-subsystem resets one stage at a time after POR,
// button or software request, waiting for each stage to acknowledge.
module ups_rst_seq #(
  parameter int NUM_STAGES  = 3,
  parameter int HOLD_CYC    = 32,
  parameter int STAGE_DLY   = 16,
  parameter int ACK_TIMEOUT = 255,
  parameter int BTN_FILT    = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ext_rst_n,
  input  logic                  sw_rst_req,
  input  logic [NUM_STAGES-1:0] stage_ack,
  output logic [NUM_STAGES-1:0] stage_rst,
  output logic                  seq_done,
  output logic                  seq_fault,
  output logic [1:0]            rst_cause
);

  localparam int M1   = (HOLD_CYC > STAGE_DLY) ? HOLD_CYC : STAGE_DLY;
  localparam int MAXB = (M1 > ACK_TIMEOUT) ? M1 : ACK_TIMEOUT;
  localparam int CW   = $clog2(MAXB) + 1;
  localparam int FW   = $clog2(BTN_FILT) + 1;
  localparam int IW   = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

  localparam logic [CW-1:0] HOLD_END = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] GAP_END  = CW'(STAGE_DLY - 1);
  localparam logic [CW-1:0] ACK_END  = CW'(ACK_TIMEOUT - 1);
  localparam logic [FW-1:0] FLT_END  = FW'(BTN_FILT - 1);
  localparam logic [IW-1:0] LAST     = IW'(NUM_STAGES - 1);

  typedef enum logic [2:0] {
    HOLD, REL, WAIT_ACK, GAP, DONE, FAULT
  } state_t;

  state_t          state;
  logic [IW-1:0]   idx;
  logic [CW-1:0]   cnt;
  logic            sync1;
  logic            sync2;
  logic            btn_lvl;
  logic [FW-1:0]   flt;
  logic            btn_req;
  logic            req;

  assign btn_req = ~btn_lvl;
  assign req     = btn_req | sw_rst_req;

  // Level flips only after BTN_FILT consecutive samples disagree with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1   <= 1'b1;
      sync2   <= 1'b1;
      btn_lvl <= 1'b1;
      flt     <= '0;
    end else begin
      sync1 <= ext_rst_n;
      sync2 <= sync1;
      if (sync2 == btn_lvl) begin
        flt <= '0;
      end else if (flt == FLT_END) begin
        btn_lvl <= sync2;
        flt     <= '0;
      end else begin
        flt <= flt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= HOLD;
      idx       <= '0;
      cnt       <= '0;
      stage_rst <= '1;
      seq_done  <= 1'b0;
      seq_fault <= 1'b0;
      rst_cause <= 2'b00;
    end else if (req) begin
      state     <= HOLD;
      idx       <= '0;
      cnt       <= '0;
      stage_rst <= '1;
      seq_done  <= 1'b0;
      seq_fault <= 1'b0;
      rst_cause <= btn_req ? 2'b01 : 2'b10;
    end else begin
      unique case (state)
        HOLD: begin
          stage_rst <= '1;
          seq_done  <= 1'b0;
          seq_fault <= 1'b0;
          if (cnt == HOLD_END) begin
            cnt   <= '0;
            idx   <= '0;
            state <= REL;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        REL: begin
          stage_rst[idx] <= 1'b0;
          cnt            <= '0;
          state          <= WAIT_ACK;
        end
        WAIT_ACK: begin
          if (stage_ack[idx]) begin
            cnt   <= '0;
            state <= GAP;
          end else if (cnt == ACK_END) begin
            cnt   <= '0;
            state <= FAULT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        GAP: begin
          if (cnt == GAP_END) begin
            cnt <= '0;
            if (idx == LAST) begin
              state <= DONE;
            end else begin
              idx   <= idx + 1'b1;
              state <= REL;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          stage_rst <= '0;
          seq_done  <= 1'b1;
        end
        FAULT: begin
          stage_rst <= '1;
          seq_fault <= 1'b1;
          seq_done  <= 1'b0;
        end
        default: state <= HOLD;
      endcase
    end
  end

endmodule

// File: tb/tb_ups_rst_seq.sv
// tb_ups_rst_seq: scenario tasks plus randomized traffic against an
// event-timeline reference model of the reset sequencer.
module tb_ups_rst_seq;

  localparam int N  = 3;
  localparam int HC = 32;
  localparam int SD = 16;
  localparam int AT = 255;
  localparam int BF = 8;

  localparam int M_HOLD  = 0;
  localparam int M_WAIT  = 1;
  localparam int M_GAP   = 2;
  localparam int M_DONE  = 3;
  localparam int M_FLTP  = 4;
  localparam int M_FLT   = 5;

  logic         clk = 1'b0;
  logic         rst;
  logic         ext_rst_n;
  logic         sw_rst_req;
  logic [N-1:0] stage_ack;
  logic [N-1:0] stage_rst;
  logic         seq_done;
  logic         seq_fault;
  logic [1:0]   rst_cause;

  int checks = 0;
  int errors = 0;
  int edge_n = -4;

  logic [N-1:0] exp_rst;
  logic         exp_done;
  logic         exp_fault;
  logic [1:0]   exp_cause;
  logic         m_lvl;
  logic         eq[$];
  int           m_mode;
  int           m_next;
  int           m_r;
  int           m_s;

  ups_rst_seq #(
    .NUM_STAGES(N), .HOLD_CYC(HC), .STAGE_DLY(SD),
    .ACK_TIMEOUT(AT), .BTN_FILT(BF)
  ) dut (
    .clk(clk), .rst(rst), .ext_rst_n(ext_rst_n),
    .sw_rst_req(sw_rst_req), .stage_ack(stage_ack),
    .stage_rst(stage_rst), .seq_done(seq_done),
    .seq_fault(seq_fault), .rst_cause(rst_cause)
  );

  always #5 clk = ~clk;

  // Timeline model: each release is scheduled from the edge that began it.
  task automatic model_edge(input logic r, input logic s,
                            input logic e, input logic [N-1:0] a);
    logic btn;
    bit   flip;
    int   len;
    if (r) begin
      exp_rst = '1; exp_done = 0; exp_fault = 0; exp_cause = 2'b00;
      m_lvl = 1'b1; eq.delete();
      m_mode = M_HOLD; m_next = edge_n + 1 + HC; m_s = 0;
      return;
    end
    btn  = !m_lvl;
    len  = eq.size();
    flip = 1;
    for (int j = len - 1 - BF; j <= len - 2; j++)
      if (((j < 0) ? 1'b1 : eq[j]) == m_lvl) flip = 0;
    eq.push_back(e);
    if (flip) m_lvl = !m_lvl;
    if (btn || s) begin
      exp_rst = '1; exp_done = 0; exp_fault = 0;
      exp_cause = btn ? 2'b01 : 2'b10;
      m_mode = M_HOLD; m_next = edge_n + 1 + HC; m_s = 0;
      return;
    end
    case (m_mode)
      M_HOLD: if (edge_n == m_next) begin
        m_s = 0; exp_rst[0] = 1'b0; m_r = edge_n; m_mode = M_WAIT;
      end
      M_WAIT: if (a[m_s]) begin
        m_next = edge_n + SD + 1; m_mode = M_GAP;
      end else if (edge_n == m_r + AT) begin
        m_mode = M_FLTP;
      end
      M_GAP: if (edge_n == m_next) begin
        if (m_s == N - 1) begin
          exp_rst = '0; exp_done = 1; m_mode = M_DONE;
        end else begin
          m_s++; exp_rst[m_s] = 1'b0; m_r = edge_n; m_mode = M_WAIT;
        end
      end
      M_FLTP: begin
        exp_rst = '1; exp_fault = 1; exp_done = 0; m_mode = M_FLT;
      end
      default: ;
    endcase
  endtask

  task automatic tick(input logic r, input logic s,
                      input logic e, input logic [N-1:0] a);
    rst = r; sw_rst_req = s; ext_rst_n = e; stage_ack = a;
    @(posedge clk);
    edge_n++;
    model_edge(r, s, e, a);
    @(negedge clk);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 1'b1, '0);
    checks++;
    if (stage_rst !== 3'b111) begin
      errors++; $display("FAIL reset_rst got %b want 111", stage_rst);
    end
    checks++;
    if (seq_done !== 1'b0 || seq_fault !== 1'b0) begin
      errors++; $display("FAIL reset_flags got %b%b want 00", seq_done, seq_fault);
    end
    checks++;
    if (rst_cause !== 2'b00) begin
      errors++; $display("FAIL reset_cause got %b want 00", rst_cause);
    end
  endtask

  task automatic test_por();
    int base = edge_n;
    int fall[N];
    int done_at = -1;
    for (int i = 0; i < N; i++) fall[i] = -1;
    for (int c = 0; c < 95; c++) begin
      tick(1'b0, 1'b0, 1'b1, '1);
      checks++;
      if ({stage_rst, seq_done, seq_fault, rst_cause} !==
          {exp_rst, exp_done, exp_fault, exp_cause}) begin
        errors++;
        $display("FAIL por_seq edge %0d got %b want %b", edge_n,
          {stage_rst, seq_done, seq_fault, rst_cause},
          {exp_rst, exp_done, exp_fault, exp_cause});
      end
      for (int i = 0; i < N; i++)
        if (fall[i] < 0 && stage_rst[i] == 1'b0) fall[i] = edge_n;
      if (done_at < 0 && seq_done == 1'b1) done_at = edge_n;
    end
    for (int i = 0; i < N; i++) begin
      checks++;
      if (fall[i] != base + 1 + HC + i * (SD + 2)) begin
        errors++;
        $display("FAIL por_fall%0d got %0d want %0d", i, fall[i] - base - 1,
          HC + i * (SD + 2));
      end
    end
    checks++;
    if (done_at != base + 1 + HC + N * (SD + 2) || rst_cause !== 2'b00) begin
      errors++;
      $display("FAIL por_done got %0d cause %b want %0d cause 00",
        done_at - base - 1, rst_cause, HC + N * (SD + 2));
    end
  endtask

  task automatic test_fault();
    int base, fall1 = -1, flt_at = -1;
    tick(1'b1, 1'b0, 1'b1, '0);
    base = edge_n;
    for (int c = 0; c < 330; c++) begin
      tick(1'b0, 1'b0, 1'b1, 3'b001 | (3'($urandom) & 3'b100));
      checks++;
      if ({stage_rst, seq_done, seq_fault, rst_cause} !==
          {exp_rst, exp_done, exp_fault, exp_cause}) begin
        errors++;
        $display("FAIL fault_seq edge %0d got %b want %b", edge_n,
          {stage_rst, seq_done, seq_fault, rst_cause},
          {exp_rst, exp_done, exp_fault, exp_cause});
      end
      if (fall1 < 0 && stage_rst[1] == 1'b0) fall1 = edge_n;
      if (flt_at < 0 && seq_fault == 1'b1) flt_at = edge_n;
    end
    checks++;
    if (fall1 != base + 1 + HC + SD + 2) begin
      errors++;
      $display("FAIL fault_fall1 got %0d want %0d", fall1 - base - 1, HC + SD + 2);
    end
    checks++;
    if (flt_at != fall1 + AT + 1) begin
      errors++;
      $display("FAIL fault_time got %0d want %0d", flt_at - fall1, AT + 1);
    end
    checks++;
    if (stage_rst !== 3'b111 || seq_fault !== 1'b1 || seq_done !== 1'b0) begin
      errors++;
      $display("FAIL fault_sticky got %b %b%b want 111 10",
        stage_rst, seq_fault, seq_done);
    end
  endtask

  task automatic test_sw_restart();
    int q;
    int fall[N];
    int done_at = -1;
    tick(1'b0, 1'b1, 1'b1, '1);
    checks++;
    if ({stage_rst, seq_done, seq_fault, rst_cause} !== 7'b111_0_0_10) begin
      errors++;
      $display("FAIL sw_from_fault got %b want 1110010",
        {stage_rst, seq_done, seq_fault, rst_cause});
    end
    for (int c = 0; c < 100; c++) begin
      tick(1'b0, 1'b0, 1'b1, '1);
      checks++;
      if ({stage_rst, seq_done, seq_fault, rst_cause} !==
          {exp_rst, exp_done, exp_fault, exp_cause}) begin
        errors++;
        $display("FAIL sw_seq edge %0d got %b want %b", edge_n,
          {stage_rst, seq_done, seq_fault, rst_cause},
          {exp_rst, exp_done, exp_fault, exp_cause});
      end
    end
    tick(1'b0, 1'b1, 1'b1, '1);
    q = edge_n;
    checks++;
    if ({stage_rst, seq_done, seq_fault, rst_cause} !== 7'b111_0_0_10) begin
      errors++;
      $display("FAIL sw_from_done got %b want 1110010",
        {stage_rst, seq_done, seq_fault, rst_cause});
    end
    for (int i = 0; i < N; i++) fall[i] = -1;
    for (int c = 0; c < 100; c++) begin
      tick(1'b0, 1'b0, 1'b1, '1);
      for (int i = 0; i < N; i++)
        if (fall[i] < 0 && stage_rst[i] == 1'b0) fall[i] = edge_n;
      if (done_at < 0 && seq_done == 1'b1) done_at = edge_n;
    end
    for (int i = 0; i < N; i++) begin
      checks++;
      if (fall[i] != q + 1 + HC + i * (SD + 2)) begin
        errors++;
        $display("FAIL sw_fall%0d got %0d want %0d", i, fall[i] - q,
          1 + HC + i * (SD + 2));
      end
    end
    checks++;
    if (done_at != q + 1 + HC + N * (SD + 2)) begin
      errors++;
      $display("FAIL sw_done got %0d want %0d", done_at - q, 1 + HC + N * (SD + 2));
    end
  endtask

  task automatic test_btn();
    int a, rst_at = -1, fall0 = -1;
    for (int i = 0; i < 30; i++) begin
      tick(1'b0, 1'b0, !(i < 5), '1);
      checks++;
      if ({stage_rst, seq_done, seq_fault, rst_cause} !==
          {exp_rst, exp_done, exp_fault, exp_cause}) begin
        errors++;
        $display("FAIL glitch_seq edge %0d got %b want %b", edge_n,
          {stage_rst, seq_done, seq_fault, rst_cause},
          {exp_rst, exp_done, exp_fault, exp_cause});
      end
    end
    checks++;
    if (seq_done !== 1'b1 || rst_cause !== 2'b10) begin
      errors++;
      $display("FAIL glitch_ignored got done %b cause %b want 1 10",
        seq_done, rst_cause);
    end
    a = edge_n + 1;
    for (int i = 0; i < 100; i++) begin
      tick(1'b0, 1'b0, !(i < 20), '1);
      checks++;
      if ({stage_rst, seq_done, seq_fault, rst_cause} !==
          {exp_rst, exp_done, exp_fault, exp_cause}) begin
        errors++;
        $display("FAIL press_seq edge %0d got %b want %b", edge_n,
          {stage_rst, seq_done, seq_fault, rst_cause},
          {exp_rst, exp_done, exp_fault, exp_cause});
      end
      if (rst_at < 0 && stage_rst != '0) rst_at = edge_n;
      if (rst_at >= 0 && fall0 < 0 && stage_rst[0] == 1'b0) fall0 = edge_n;
    end
    checks++;
    if (rst_at != a + 2 + BF) begin
      errors++;
      $display("FAIL press_latency got %0d want %0d", rst_at - a, 2 + BF);
    end
    checks++;
    if (rst_cause !== 2'b01) begin
      errors++; $display("FAIL press_cause got %b want 01", rst_cause);
    end
    checks++;
    if (fall0 != a + 20 + 2 + BF + HC) begin
      errors++;
      $display("FAIL press_hold got %0d want %0d", fall0 - a, 22 + BF + HC);
    end
  endtask

  task automatic test_simul();
    for (int i = 0; i < 30; i++) begin
      tick(1'b0, i == 2 + BF, !(i < 12), '1);
      checks++;
      if ({stage_rst, seq_done, seq_fault, rst_cause} !==
          {exp_rst, exp_done, exp_fault, exp_cause}) begin
        errors++;
        $display("FAIL simul_seq edge %0d got %b want %b", edge_n,
          {stage_rst, seq_done, seq_fault, rst_cause},
          {exp_rst, exp_done, exp_fault, exp_cause});
      end
      if (i == 2 + BF) begin
        checks++;
        if (rst_cause !== 2'b01 || stage_rst !== 3'b111) begin
          errors++;
          $display("FAIL simul_cause got %b rst %b want 01 111",
            rst_cause, stage_rst);
        end
      end
    end
  endtask

  task automatic test_mid_gap();
    int q2, fall0 = -1;
    logic [N-1:0] snap = '1;
    tick(1'b0, 1'b1, 1'b1, '1);
    for (int c = 0; c < 56; c++) begin
      tick(1'b0, 1'b0, 1'b1, '1);
      checks++;
      if ({stage_rst, seq_done, seq_fault, rst_cause} !==
          {exp_rst, exp_done, exp_fault, exp_cause}) begin
        errors++;
        $display("FAIL gap_seq edge %0d got %b want %b", edge_n,
          {stage_rst, seq_done, seq_fault, rst_cause},
          {exp_rst, exp_done, exp_fault, exp_cause});
      end
    end
    tick(1'b0, 1'b1, 1'b1, '1);
    q2 = edge_n;
    checks++;
    if (stage_rst !== 3'b111 || seq_done !== 1'b0 || rst_cause !== 2'b10) begin
      errors++;
      $display("FAIL gap_abort got %b %b %b want 111 0 10",
        stage_rst, seq_done, rst_cause);
    end
    for (int c = 0; c < 40; c++) begin
      tick(1'b0, 1'b0, 1'b1, '1);
      if (fall0 < 0 && stage_rst != 3'b111) begin
        fall0 = edge_n; snap = stage_rst;
      end
    end
    checks++;
    if (fall0 != q2 + 1 + HC || snap !== 3'b110) begin
      errors++;
      $display("FAIL gap_restart got %0d %b want %0d 110",
        fall0 - q2, snap, 1 + HC);
    end
  endtask

  task automatic test_rst_mid();
    int r, fall0 = -1;
    tick(1'b0, 1'b1, 1'b1, '0);
    for (int c = 0; c < HC + 10; c++) tick(1'b0, 1'b0, 1'b1, '0);
    checks++;
    if (stage_rst !== 3'b110) begin
      errors++; $display("FAIL rstmid_wait got %b want 110", stage_rst);
    end
    tick(1'b1, 1'b0, 1'b1, '0);
    r = edge_n;
    checks++;
    if ({stage_rst, seq_done, seq_fault, rst_cause} !== 7'b111_0_0_00) begin
      errors++;
      $display("FAIL rstmid_vals got %b want 1110000",
        {stage_rst, seq_done, seq_fault, rst_cause});
    end
    for (int c = 0; c < 40; c++) begin
      tick(1'b0, 1'b0, 1'b1, '1);
      if (fall0 < 0 && stage_rst[0] == 1'b0) fall0 = edge_n;
    end
    checks++;
    if (fall0 != r + 1 + HC) begin
      errors++;
      $display("FAIL rstmid_restart got %0d want %0d", fall0 - r, 1 + HC);
    end
  endtask

  task automatic test_random();
    int press = 0;
    int dead = 0;
    logic [N-1:0] a;
    for (int c = 0; c < 3000; c++) begin
      if (press == 0 && $urandom_range(0, 199) == 0)
        press = $urandom_range(1, 25);
      if (dead == 0 && $urandom_range(0, 299) == 0)
        dead = $urandom_range(100, 400);
      a = 3'($urandom) | 3'($urandom);
      if (dead > 0) begin a = 3'b011; dead--; end
      tick($urandom_range(0, 499) == 0, $urandom_range(0, 149) == 0,
           press == 0, a);
      if (press > 0) press--;
      checks++;
      if ({stage_rst, seq_done, seq_fault, rst_cause} !==
          {exp_rst, exp_done, exp_fault, exp_cause}) begin
        errors++;
        $display("FAIL rand_seq edge %0d got %b want %b", edge_n,
          {stage_rst, seq_done, seq_fault, rst_cause},
          {exp_rst, exp_done, exp_fault, exp_cause});
      end
    end
  endtask

  initial begin
    rst = 1'b1; sw_rst_req = 1'b0; ext_rst_n = 1'b1; stage_ack = '0;
    test_reset();
    test_por();
    test_fault();
    test_sw_restart();
    test_btn();
    test_simul();
    test_mid_gap();
    test_rst_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
